// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin arbiter: drains CHANNEL_NUMBER AXI-Stream inputs
// into one registered AXI-Stream output. A granted input owns the output
// until its TLAST beat has been accepted.

package axis_rr_arbiter_pkg;

  localparam int AXIS_DATA_WIDTH = 40;
`ifdef TID_PRESENT
  localparam int ID_WIDTH = 4;
`endif
`ifdef TDEST_PRESENT
  localparam int DEST_WIDTH = 4;
`endif
`ifdef TUSER_PRESENT
  localparam int USER_WIDTH = 4;
`endif

  typedef struct packed {
`ifdef TID_PRESENT
    logic [ID_WIDTH-1:0]        tid;
`endif
`ifdef TDEST_PRESENT
    logic [DEST_WIDTH-1:0]      tdest;
`endif
`ifdef TUSER_PRESENT
    logic [USER_WIDTH-1:0]      tuser;
`endif
    logic [AXIS_DATA_WIDTH-1:0] tdata;
    logic                       tlast;
  } axis_data_t;

  typedef struct packed {
    axis_data_t data;
    logic       tvalid;
  } axis_mosi_t;

  typedef struct packed {
    logic tready;
  } axis_miso_t;

endpackage

module axis_rr_arbiter
  import axis_rr_arbiter_pkg::*;
#(
  parameter int  CHANNEL_NUMBER = 5,
  localparam int IDX_W          = $clog2(CHANNEL_NUMBER)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  axis_mosi_t       in_mosi_i [CHANNEL_NUMBER],
  output axis_miso_t       in_miso_o [CHANNEL_NUMBER],
  output axis_mosi_t       out_mosi_o,
  input  axis_miso_t       out_miso_i,
  output logic [IDX_W-1:0] grant_o
);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          prio_q, prio_d;
  logic [IDX_W-1:0]          grant_q, grant_d;
  logic [IDX_W-1:0]          sel;
  logic [IDX_W-1:0]          scan;
  logic [IDX_W-1:0]          acc_ch;
  logic                      any_valid;
  logic                      slot_free;
  logic                      accept;
  logic [CHANNEL_NUMBER-1:0] ready;
  axis_mosi_t                out_q;
  int                        wrap_sum;

  // Channel index that follows idx in round-robin order.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(CHANNEL_NUMBER - 1)) ? '0 : idx + IDX_W'(1);
  endfunction

  // First valid input found scanning upward from the priority pointer.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    sel       = '0;
    scan      = '0;
    wrap_sum  = 0;
    any_valid = 1'b0;
    for (int k = 0; k < CHANNEL_NUMBER; k++) begin
      wrap_sum = int'(prio_q) + k;
      if (wrap_sum >= CHANNEL_NUMBER) wrap_sum = wrap_sum - CHANNEL_NUMBER;
      scan = IDX_W'(wrap_sum);
      if (!any_valid && in_mosi_i[scan].tvalid) begin
        sel       = scan;
        any_valid = 1'b1;
      end
    end
  end

  // Grant FSM: pick a packet owner in IDLE, hold it in LOCKED until TLAST.
  always_comb begin
    slot_free = !out_q.tvalid || out_miso_i.tready;
    state_d   = state_q;
    prio_d    = prio_q;
    grant_d   = grant_q;
    ready     = '0;
    accept    = 1'b0;
    acc_ch    = grant_q;
    // Upstream sees no TREADY while reset is asserted.
    if (rst_n_i) begin
      unique case (state_q)
        IDLE: begin
          if (any_valid && slot_free) begin
            ready[sel] = 1'b1;
            accept     = 1'b1;
            acc_ch     = sel;
            grant_d    = sel;
            if (in_mosi_i[sel].data.tlast) prio_d  = next_idx(sel);
            else                           state_d = LOCKED;
          end
        end
        LOCKED: begin
          ready[grant_q] = slot_free;
          if (slot_free && in_mosi_i[grant_q].tvalid) begin
            accept = 1'b1;
            if (in_mosi_i[grant_q].data.tlast) begin
              state_d = IDLE;
              prio_d  = next_idx(grant_q);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Fan the ready vector out to the per-input handshake structs.
  always_comb begin
    for (int i = 0; i < CHANNEL_NUMBER; i++) in_miso_o[i].tready = ready[i];
  end

  // Arbitration state registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      prio_q  <= '0;
      grant_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      prio_q  <= prio_d;
      grant_q <= grant_d;
    end
  end

  // Output slice: reload on accept, drop valid once the beat is popped.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_q <= '0;
    end else if (accept) begin
      out_q.data   <= in_mosi_i[acc_ch].data;
      out_q.tvalid <= 1'b1;
    end else if (out_miso_i.tready) begin
      out_q.tvalid <= 1'b0;
    end
  end

  assign out_mosi_o = out_q;
  assign grant_o    = grant_q;

endmodule
